// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// | npu_pkg : shared types and helpers for the NPU convolution engine       |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

package npu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_MAC  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } conv_state_e;

  // Accumulator width that can hold the sum of all kernel products without overflow.
  function automatic int acc_width(input int dw, input int ww, input int taps);
    return dw + ww + $clog2(taps);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// | conv_line_buffer : K_H-1 raster lines, exposes one K_H-tall pixel column|
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module conv_line_buffer
  import npu_pkg::*;
#(
  parameter int K_H   = 3,
  parameter int IMG_W = 15,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              shift_en,
  input  logic [DW-1:0]     din,
  output logic [K_H*DW-1:0] col_taps
);

  localparam int DEPTH = (K_H - 1) * IMG_W;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Row K_H-1 is the incoming pixel; row r sits (K_H-1-r) full lines back.
  assign col_taps[(K_H-1)*DW +: DW] = din;

  for (genvar r = 0; r < K_H - 1; r++) begin : g_tap
    assign col_taps[r*DW +: DW] = mem[(K_H-1-r)*IMG_W - 1];
  end

endmodule

`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
// ---------------------------------------------------------------------------
// | conv2d_stream_engine : streaming KxK convolution, OUT_CH parallel lanes |
// | Optional macro CONV2D_SAT_EN : saturating narrowing + sat_flags port    |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module conv2d_stream_engine
  import npu_pkg::*;
#(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IMG_H  = 16,
  parameter int IMG_W  = 15,
  parameter int OUT_CH = 10,
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int OUT_W  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         relu_en,
  input  logic                         w_we,
  input  logic [$clog2(OUT_CH)-1:0]    w_ch,
  input  logic [$clog2(K_H*K_W)-1:0]   w_tap,
  input  logic [WW-1:0]                w_data,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [DW-1:0]                pix_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_CH*OUT_W-1:0]      out_data,
  output logic                         busy,
  output logic                         done
`ifdef CONV2D_SAT_EN
  ,
  output logic [OUT_CH-1:0]            sat_flags
`endif
);

  localparam int TAPS  = K_H * K_W;
  localparam int ACC_W = acc_width(DW, WW, TAPS);
  localparam int TW    = $clog2(TAPS);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int CW    = $clog2(IMG_W);

  conv_state_e          state;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [TW-1:0]        tap;
  logic                 relu_q;
  logic                 last_q;

  logic signed [ACC_W-1:0] acc     [OUT_CH];
  logic signed [ACC_W-1:0] acc_nxt [OUT_CH];
  logic [OUT_CH*OUT_W-1:0] res;
`ifdef CONV2D_SAT_EN
  logic [OUT_CH-1:0]       sat_hit;
`endif

  logic signed [WW-1:0]  w_ram [OUT_CH][TAPS];
  logic signed [DW-1:0]  win   [TAPS];
  logic [K_H*DW-1:0]     col_taps;

  logic accept;
  logic win_full;
  logic col_last;
  logic row_last;

  assign accept   = pix_valid && pix_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign win_full = (32'(row) >= K_H - 1) && (32'(col) >= K_W - 1);

  conv_line_buffer #(
    .K_H   (K_H),
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_line_buffer (
    .clk      (clk),
    .shift_en (accept),
    .din      (pix_data),
    .col_taps (col_taps)
  );

  // Window: newest column enters at c=K_W-1, older columns slide toward c=0.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W - 1; c++) begin
          win[r*K_W + c] <= win[r*K_W + c + 1];
        end
        win[r*K_W + K_W - 1] <= $signed(col_taps[r*DW +: DW]);
      end
    end
  end

  // Weights are only writable while no frame is using them.
  always_ff @(posedge clk) begin
    if (w_we && (state == S_IDLE || state == S_DONE) &&
        (32'(w_ch) < OUT_CH) && (32'(w_tap) < TAPS)) begin
      w_ram[w_ch][w_tap] <= $signed(w_data);
    end
  end

  for (genvar ch = 0; ch < OUT_CH; ch++) begin : g_lane
    logic signed [DW+WW-1:0] prod;
    logic signed [ACC_W-1:0] relu_v;
    logic signed [OUT_W-1:0] narrow;

    assign prod        = (DW+WW)'(w_ram[ch][tap]) * (DW+WW)'(win[tap]);
    assign acc_nxt[ch] = acc[ch] + ACC_W'(prod);
    assign relu_v      = (relu_q && acc_nxt[ch][ACC_W-1]) ? '0 : acc_nxt[ch];

    if (OUT_W >= ACC_W) begin : g_wide
      assign narrow = OUT_W'(relu_v);
`ifdef CONV2D_SAT_EN
      assign sat_hit[ch] = 1'b0;
`endif
    end else begin : g_narrow
`ifdef CONV2D_SAT_EN
      logic ovf;
      // Fits only if every bit above the OUT_W sign bit matches the sign.
      assign ovf = (relu_v[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){relu_v[ACC_W-1]}});
      assign narrow = !ovf ? OUT_W'(relu_v) :
                      relu_v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                        {1'b0, {(OUT_W-1){1'b1}}};
      assign sat_hit[ch] = ovf;
`else
      assign narrow = OUT_W'(relu_v);
`endif
    end

    assign res[ch*OUT_W +: OUT_W] = narrow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      relu_q    <= 1'b0;
      last_q    <= 1'b0;
      pix_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      for (int ch = 0; ch < OUT_CH; ch++) begin
        acc[ch] <= '0;
      end
`ifdef CONV2D_SAT_EN
      sat_flags <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FILL;
            row       <= '0;
            col       <= '0;
            relu_q    <= relu_en;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
`ifdef CONV2D_SAT_EN
            sat_flags <= '0;
`endif
          end
        end

        S_FILL: begin
          if (accept) begin
            if (col_last) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            last_q <= row_last && col_last;
            if (win_full) begin
              state     <= S_MAC;
              tap       <= '0;
              pix_ready <= 1'b0;
              for (int ch = 0; ch < OUT_CH; ch++) begin
                acc[ch] <= '0;
              end
            end
          end
        end

        S_MAC: begin
          for (int ch = 0; ch < OUT_CH; ch++) begin
            acc[ch] <= acc_nxt[ch];
          end
          if (tap == TW'(TAPS - 1)) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_data  <= res;
`ifdef CONV2D_SAT_EN
            sat_flags <= sat_flags | sat_hit;
`endif
          end else begin
            tap <= tap + TW'(1);
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FILL;
              pix_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          pix_ready <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
// ---------------------------------------------------------------------------
// | tb_conv2d_stream_engine : scoreboard bench with a direct-convolution    |
// | reference model; follows CONV2D_SAT_EN when it is defined               |
// | Rev 1.0 : initial release                                               |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv2d_stream_engine;

  localparam int K_H    = 3;
  localparam int K_W    = 3;
  localparam int IMG_H  = 5;
  localparam int IMG_W  = 5;
  localparam int OUT_CH = 4;
  localparam int DW     = 8;
  localparam int WW     = 8;
  localparam int OUT_W  = 16;
  localparam int TAPS   = K_H * K_W;
  localparam int VW     = OUT_CH * OUT_W;
  localparam int LO     = -(2 ** (OUT_W - 1));
  localparam int HI     = (2 ** (OUT_W - 1)) - 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic                        relu_en = 1'b0;
  logic                        w_we = 1'b0;
  logic [$clog2(OUT_CH)-1:0]   w_ch = '0;
  logic [$clog2(TAPS)-1:0]     w_tap = '0;
  logic [WW-1:0]               w_data = '0;
  logic                        pix_valid = 1'b0;
  logic                        pix_ready;
  logic [DW-1:0]               pix_data = '0;
  logic                        out_valid;
  logic                        out_ready;
  logic [VW-1:0]               out_data;
  logic                        busy;
  logic                        done;
`ifdef CONV2D_SAT_EN
  logic [OUT_CH-1:0]           sat_flags;
`endif

  conv2d_stream_engine #(
    .K_H(K_H), .K_W(K_W), .IMG_H(IMG_H), .IMG_W(IMG_W),
    .OUT_CH(OUT_CH), .DW(DW), .WW(WW), .OUT_W(OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .relu_en   (relu_en),
    .w_we      (w_we),
    .w_ch      (w_ch),
    .w_tap     (w_tap),
    .w_data    (w_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef CONV2D_SAT_EN
    ,
    .sat_flags (sat_flags)
`endif
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                done_cnt = 0;
  int                out_cnt = 0;
  int                lat_req = 0;
  int                lat_seen = 0;
  int                acc_edge = 0;
  int                bp_mode = 0;  // 0: ready high, 1: random, 2: held low
  int                wm [OUT_CH][TAPS];
  int                pm [IMG_H][IMG_W];
  logic [VW-1:0]     sbq [$];
  logic [OUT_CH-1:0] exp_sat = '0;

  task automatic chk(input bit ok, input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] narrow(input int s);
    int t;
    t = s;
`ifdef CONV2D_SAT_EN
    if (s > HI) t = HI;
    else if (s < LO) t = LO;
`endif
    return t[OUT_W-1:0];
  endfunction

  // Reference: plain 2-D convolution over every fully-inside window, raster order.
  task automatic push_expected(input bit relu);
    logic [VW-1:0] v;
    int s;
    exp_sat = '0;
    for (int r = K_H - 1; r < IMG_H; r++) begin
      for (int c = K_W - 1; c < IMG_W; c++) begin
        for (int ch = 0; ch < OUT_CH; ch++) begin
          s = 0;
          for (int kr = 0; kr < K_H; kr++)
            for (int kc = 0; kc < K_W; kc++)
              s += wm[ch][kr*K_W + kc] * pm[r-K_H+1+kr][c-K_W+1+kc];
          if (relu && s < 0) s = 0;
          if (s > HI || s < LO) exp_sat[ch] = 1'b1;
          v[ch*OUT_W +: OUT_W] = narrow(s);
        end
        sbq.push_back(v);
      end
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops, stall stability, latency and done bookkeeping.
  initial begin
    logic [VW-1:0] held;
    logic [VW-1:0] e;
    bit            hold_pend;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
        continue;
      end
      if (done) begin
        done_cnt++;
        chk(sbq.size() == 0, "queue_empty_at_done", VW'(sbq.size()), '0);
      end
      if (lat_seen != lat_req && out_valid) begin
        lat_seen = lat_req;
        chk(cyc - acc_edge == TAPS, "latency", VW'(cyc - acc_edge), VW'(TAPS));
      end
      if (hold_pend)
        chk(out_valid && out_data === held, "stall_hold", out_data, held);
      hold_pend = 1'b0;
      if (out_valid) begin
        chk(!pix_ready, "pix_ready_low_in_out", VW'(pix_ready), '0);
        if (out_ready) begin
          out_cnt++;
          if (sbq.size() == 0) begin
            chk(1'b0, "unexpected_output", out_data, '0);
          end else begin
            e = sbq.pop_front();
            chk(out_data === e, "out_data", out_data, e);
          end
        end else begin
          held = out_data;
          hold_pend = 1'b1;
        end
      end
    end
  end

  task automatic load_weights();
    for (int ch = 0; ch < OUT_CH; ch++) begin
      for (int t = 0; t < TAPS; t++) begin
        w_we = 1'b1;
        w_ch = ($clog2(OUT_CH))'(ch);
        w_tap = ($clog2(TAPS))'(t);
        w_data = WW'(wm[ch][t]);
        @(posedge clk);
        #1;
      end
    end
    w_we = 1'b0;
  endtask

  task automatic send_pix(input int r, input int c);
    bit ok;
    ok = 1'b0;
    pix_valid = 1'b1;
    pix_data = DW'(pm[r][c]);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    pix_valid = 1'b0;
    chk(ok, "pixel_accept_timeout", VW'(ok), VW'(1));
    if (r == K_H - 1 && c == K_W - 1) begin
      acc_edge = cyc;
      lat_req++;
    end
  endtask

  task automatic send_frame(input bit gaps, input bit wr_mid);
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        if (wr_mid && r == 0 && c == 3) begin
          w_we = 1'b1; w_ch = '0; w_tap = 4; w_data = 8'd99;
          @(posedge clk);
          #1;
          w_we = 1'b0;
        end
        send_pix(r, c);
      end
    end
  endtask

  task automatic wait_done(input bit wr_in_done, input int new_w);
    int  d0;
    bit  seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "done_timeout", VW'(seen), VW'(1));
    if (wr_in_done) begin
      w_we = 1'b1; w_ch = 2'd1; w_tap = '0; w_data = WW'(new_w);
      wm[1][0] = new_w;
    end
    @(posedge clk);
    #1;
    w_we = 1'b0;
    chk(done_cnt == d0 + 1, "done_once", VW'(done_cnt - d0), VW'(1));
    chk(!busy && !done, "idle_after_done", VW'({busy, done}), '0);
`ifdef CONV2D_SAT_EN
    chk(sat_flags === exp_sat, "sat_flags", VW'(sat_flags), VW'(exp_sat));
`endif
  endtask

  task automatic run_frame(input bit relu, input bit gaps, input bit wr_mid, input bit stall,
                           input bit wr_in_done, input int new_w);
    int o0;
    push_expected(relu);
    start = 1'b1;
    relu_en = relu;
    @(posedge clk);
    #1;
    start = 1'b0;
    relu_en = 1'b0;
    if (!stall) begin
      send_frame(gaps, wr_mid);
    end else begin
      o0 = out_cnt;
      fork
        send_frame(gaps, wr_mid);
        begin
          for (int i = 0; i < 2000 && out_cnt < o0 + 3; i++) @(negedge clk);
          bp_mode = 2;
          repeat (20) @(negedge clk);
          chk(!pix_ready && out_valid, "stalled_state", VW'({pix_ready, out_valid}), VW'(1));
          bp_mode = 0;
        end
      join
    end
    wait_done(wr_in_done, new_w);
  endtask

  task automatic rand_weights();
    for (int ch = 0; ch < OUT_CH; ch++)
      for (int t = 0; t < TAPS; t++)
        wm[ch][t] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic rand_pixels();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pm[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk({pix_ready, out_valid, busy, done} == 4'b0, "reset_ctrl",
        VW'({pix_ready, out_valid, busy, done}), '0);
    chk(out_data == '0, "reset_data", out_data, '0);
`ifdef CONV2D_SAT_EN
    chk(sat_flags == '0, "reset_sat", VW'(sat_flags), '0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All ones: every channel sums to 9.
    for (int ch = 0; ch < OUT_CH; ch++) for (int t = 0; t < TAPS; t++) wm[ch][t] = 1;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) pm[r][c] = 1;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Horizontal gradient: ch0 responds with +6 everywhere.
    rand_weights();
    for (int kr = 0; kr < K_H; kr++) begin
      wm[0][kr*K_W + 0] = -1; wm[0][kr*K_W + 1] = 0; wm[0][kr*K_W + 2] = 1;
    end
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) pm[r][c] = c;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Negated kernel with ReLU: ch0 clamps to 0.
    for (int t = 0; t < TAPS; t++) wm[0][t] = -wm[0][t];
    load_weights();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Extreme magnitudes: 127 * -128 * 9 overflows OUT_W.
    for (int t = 0; t < TAPS; t++) wm[0][t] = 127;
    for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) pm[r][c] = -128;
    load_weights();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Random data, random backpressure and input gaps; weight write during fill is ignored.
    rand_weights();
    rand_pixels();
    load_weights();
    bp_mode = 1;
    run_frame(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0, 0);
    bp_mode = 0;

    // Long output stall in the middle of a frame.
    rand_pixels();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Reset while in the MAC phase aborts the frame.
    rand_pixels();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i <= (K_H - 1) * IMG_W + K_W - 1; i++) send_pix(i / IMG_W, i % IMG_W);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk({busy, out_valid, pix_ready, done} == 4'b0, "abort_ctrl",
        VW'({busy, out_valid, pix_ready, done}), '0);
    chk(out_data == '0, "abort_data", out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Weights survive reset; a weight write in the done cycle lands.
    rand_pixels();
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, int'($urandom_range(0, 255)) - 128);
    rand_pixels();
    bp_mode = 1;
    run_frame(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0, 0);
    bp_mode = 0;

    repeat (5) @(posedge clk);
    chk(sbq.size() == 0, "queue_drained", VW'(sbq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
